// File: rtl/stickman_pkg.sv
// Shared constants and types for the stickman frame-driven game blocks.
// HID keycodes, hold-counter width and the jump state encoding live here so
// every frame-driven module decodes keys the same way.
package stickman_pkg;

    localparam int HOLD_W = 6;

    localparam logic [7:0] KEY_NONE     = 8'h00;
    localparam logic [7:0] KEY_JUMP     = 8'h2C;
    localparam logic [7:0] KEY_JUMP_ALT = 8'h52;
    localparam logic [7:0] KEY_RESTART  = 8'h28;
    localparam logic [7:0] KEY_PAUSE    = 8'h13;

    localparam logic [HOLD_W-1:0] MAX_HOLD = 6'd20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        WAIT_REL = 2'd2
    } jump_state_t;

    // Spacebar and up-arrow both act as the jump key.
    function automatic logic is_jump_key(input logic [7:0] code);
        return (code == KEY_JUMP) || (code == KEY_JUMP_ALT);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: converts the VGA vertical sync into a one-Clk tick
// on its rising edge. Two registered copies of frame_clk also bring the
// asynchronous sync signal into the Clk domain.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q_r;
    logic frame_clk_qq_r;

    // Two-stage capture of frame_clk for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q_r  <= 1'b0;
            frame_clk_qq_r <= 1'b0;
        end else begin
            frame_clk_q_r  <= frame_clk;
            frame_clk_qq_r <= frame_clk_q_r;
        end
    end

    assign tick = frame_clk_q_r & ~frame_clk_qq_r;

endmodule

// File: rtl/key_event_unit.sv
// Key event unit: turns the raw USB keycode into frame-aligned game events
// (jump start pulse, capped jump hold level, restart pulse, pause flag).
// All decisions are taken on the frame tick using the keycode registered in
// that same Clk cycle; codes that come and go between ticks are never seen.
// Optional build macro: PAUSE_KEY_EN enables the 'P' pause toggle; without it
// paused is tied low and 'P' is treated as no key.
import stickman_pkg::*;

module key_event_unit (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [7:0]        keycode,
    output logic              jump_start,
    output logic              jump_hold,
    output logic [HOLD_W-1:0] hold_frames,
    output logic              restart_req,
    output logic              paused
);

    logic              tick_s;
    logic [7:0]        key_q_r;
    logic              jump_dn_s;
    logic              ent_dn_s;
    logic              restart_ev_s;
    logic              frozen_s;
    logic              ent_prev_r;
    jump_state_t       state_r;
    logic              jump_start_r;
    logic              jump_hold_r;
    logic [HOLD_W-1:0] hold_frames_r;
    logic              restart_req_r;

    frame_tick_gen u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick_s)
    );

    // Register the PIO keycode every Clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q_r <= KEY_NONE;
        end else begin
            key_q_r <= keycode;
        end
    end

    // Key decode; unknown codes simply match nothing.
    always_comb begin
        jump_dn_s    = is_jump_key(key_q_r);
        ent_dn_s     = (key_q_r == KEY_RESTART);
        restart_ev_s = ent_dn_s & ~ent_prev_r;
    end

`ifdef PAUSE_KEY_EN
    logic pause_dn_s;
    logic pause_prev_r;
    logic paused_r;

    // Pause key decode.
    always_comb begin
        pause_dn_s = (key_q_r == KEY_PAUSE);
    end

    // Pause toggle on a new P press; a restart always unpauses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            paused_r     <= 1'b0;
            pause_prev_r <= 1'b0;
        end else if (tick_s) begin
            pause_prev_r <= pause_dn_s;
            if (restart_ev_s) begin
                paused_r <= 1'b0;
            end else if (pause_dn_s && !pause_prev_r) begin
                paused_r <= ~paused_r;
            end
        end
    end

    assign frozen_s = paused_r;
    assign paused   = paused_r;
`else
    assign frozen_s = 1'b0;
    assign paused   = 1'b0;
`endif

    // Jump FSM with registered event outputs; state moves only on a tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= IDLE;
            ent_prev_r    <= 1'b0;
            jump_start_r  <= 1'b0;
            jump_hold_r   <= 1'b0;
            hold_frames_r <= '0;
            restart_req_r <= 1'b0;
        end else begin
            jump_start_r  <= 1'b0;
            restart_req_r <= 1'b0;
            if (tick_s) begin
                ent_prev_r <= ent_dn_s;
                if (restart_ev_s) begin
                    // Restart wins: drop any jump and require a release.
                    restart_req_r <= 1'b1;
                    jump_hold_r   <= 1'b0;
                    state_r       <= jump_dn_s ? WAIT_REL : IDLE;
                end else if (!frozen_s) begin
                    case (state_r)
                        IDLE: begin
                            if (jump_dn_s) begin
                                state_r       <= HELD;
                                jump_start_r  <= 1'b1;
                                jump_hold_r   <= 1'b1;
                                hold_frames_r <= '0;
                            end
                        end
                        HELD: begin
                            if (!jump_dn_s) begin
                                state_r     <= IDLE;
                                jump_hold_r <= 1'b0;
                            end else if (hold_frames_r < (MAX_HOLD - 6'd1)) begin
                                hold_frames_r <= hold_frames_r + 6'd1;
                            end else begin
                                hold_frames_r <= MAX_HOLD;
                                jump_hold_r   <= 1'b0;
                                state_r       <= WAIT_REL;
                            end
                        end
                        WAIT_REL: begin
                            if (!jump_dn_s) begin
                                state_r <= IDLE;
                            end
                        end
                        default: begin
                            state_r     <= IDLE;
                            jump_hold_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign jump_start  = jump_start_r;
    assign jump_hold   = jump_hold_r;
    assign hold_frames = hold_frames_r;
    assign restart_req = restart_req_r;

endmodule

// File: tb/tb_key_event_unit.sv
// Testbench for key_event_unit: directed frame sequences followed by
// randomized key runs, checked by a scoreboard against a frame-level model.
module tb_key_event_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       jump_start;
    logic       jump_hold;
    logic [5:0] hold_frames;
    logic       restart_req;
    logic       paused;

`ifdef PAUSE_KEY_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    key_event_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .jump_start  (jump_start),
        .jump_hold   (jump_hold),
        .hold_frames (hold_frames),
        .restart_req (restart_req),
        .paused      (paused)
    );

    always #5 Clk = ~Clk;

    // {jump_start, jump_hold, hold_frames[5:0], restart_req, paused}
    typedef logic [9:0] exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Frame-level reference: a jump is "in the air" while the key is held,
    // for at most 20 frames; after the cap or a restart the key must be let go.
    bit m_jumping, m_locked, m_ent_prev, m_p_prev, m_paused;
    int m_cnt;

    task automatic model_reset();
        m_jumping = 0; m_locked = 0; m_ent_prev = 0; m_p_prev = 0;
        m_paused = 0; m_cnt = 0;
    endtask

    task automatic model_tick(input logic [7:0] k, output exp_t e);
        bit jk, ent, pz, frozen, st, rq;
        jk  = (k == 8'h2C) || (k == 8'h52);
        ent = (k == 8'h28);
        pz  = PAUSE_EN && (k == 8'h13);
        st = 0; rq = 0;
        if (ent && !m_ent_prev) begin
            rq = 1; m_paused = 0; m_jumping = 0; m_locked = jk;
        end else begin
            frozen = m_paused;
            if (pz && !m_p_prev) m_paused = !m_paused;
            if (!frozen) begin
                if (!jk) begin
                    m_jumping = 0; m_locked = 0;
                end else if (m_jumping) begin
                    if (m_cnt + 1 >= 20) begin
                        m_cnt = 20; m_jumping = 0; m_locked = 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else if (!m_locked) begin
                    m_jumping = 1; m_cnt = 0; st = 1;
                end
            end
        end
        m_ent_prev = ent;
        m_p_prev = pz;
        e = {st, m_jumping, 6'(m_cnt), rq, m_paused};
    endtask

    // One frame: present key, raise VS, hold, lower VS, optional glitch code.
    task automatic do_frame(input logic [7:0] k, input bit glitch);
        exp_t e;
        @(negedge Clk);
        keycode = k;
        @(negedge Clk);
        frame_clk = 1'b1;
        model_tick(k, e);
        exp_q.push_back(e);
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        if (glitch) keycode = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t got;
        got = {jump_start, jump_hold, hold_frames, restart_req, paused};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, 10'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        check_reset_outputs("reset_mid");
        Reset = 1'b0;
    endtask

    // Monitor: each VS rise yields one registered response to compare.
    initial begin
        exp_t got, e;
        forever begin
            @(posedge frame_clk);
            @(posedge Clk);
            @(posedge Clk);
            @(negedge Clk);
            got = {jump_start, jump_hold, hold_frames, restart_req, paused};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL frame_unexpected: got %b with no expectation queued", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL frame_outputs: got %b expected %b (start,hold,frames,req,paused) at %0t",
                             got, e, $time);
                end
            end
            @(negedge Clk);
            n_cmp++;
            if ({jump_start, restart_req} !== 2'b00) begin
                n_bad++;
                $display("FAIL pulse_width: got start/req %b expected 00 at %0t",
                         {jump_start, restart_req}, $time);
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, len;
        logic [7:0] k;
        model_reset();
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset_init");
        Reset = 1'b0;

        // Hold space 5 frames then release.
        repeat (5) do_frame(8'h2C, 1'b0);
        do_frame(8'h00, 1'b0);
        // Hold space 30 frames: cap at 20, no re-trigger until released.
        repeat (30) do_frame(8'h2C, 1'b0);
        repeat (2) do_frame(8'h00, 1'b0);
        do_frame(8'h52, 1'b0);
        do_frame(8'h00, 1'b0);
        // Space only between ticks.
        @(negedge Clk);
        keycode = 8'h2C;
        @(negedge Clk);
        keycode = 8'h00;
        do_frame(8'h00, 1'b0);
        // Enter held 10 frames then space.
        repeat (10) do_frame(8'h28, 1'b0);
        do_frame(8'h2C, 1'b0);
        do_frame(8'h00, 1'b0);
        // Reset mid-jump with space still held.
        repeat (8) do_frame(8'h2C, 1'b0);
        do_reset();
        do_frame(8'h2C, 1'b0);
        do_frame(8'h00, 1'b0);
        // Pause key sequence.
        do_frame(8'h13, 1'b0);
        do_frame(8'h00, 1'b0);
        do_frame(8'h2C, 1'b0);
        do_frame(8'h00, 1'b0);
        do_frame(8'h13, 1'b0);
        do_frame(8'h00, 1'b0);
        do_frame(8'h2C, 1'b0);
        do_frame(8'h00, 1'b0);

        // Randomized key runs.
        for (int r = 0; r < 150; r++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: k = 8'h2C;
                4:          k = 8'h52;
                5:          k = 8'h28;
                6:          k = 8'h13;
                8:          k = 8'($urandom_range(0, 255));
                default:    k = 8'h00;
            endcase
            len = $urandom_range(1, 14);
            for (int f = 0; f < len; f++) begin
                do_frame(k, ($urandom_range(0, 3) == 0));
            end
            if ($urandom_range(0, 24) == 0) do_reset();
        end

        repeat (4) @(negedge Clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
